// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Phase 2 datapath: shared fetch (T0-T2), opcode
// decode at T3, per-instruction execute states, then back to fetch or into HALT.
module control_unit #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter logic [4:0]        OP_LD    = 5'b00000,
    parameter logic [4:0]        OP_LDI   = 5'b00001,
    parameter logic [4:0]        OP_ST    = 5'b00010,
    parameter logic [4:0]        OP_IN    = 5'b10110,
    parameter logic [4:0]        OP_OUT   = 5'b10111,
    parameter logic [4:0]        OP_NOP   = 5'b11010,
    parameter logic [4:0]        OP_HALT  = 5'b11011
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] ir,
    input  logic              stop,
    output logic [DATA_W-1:0] pc_init,
    output logic              pc_init_enable,
    output logic              pc_out,
    output logic              zlo_out,
    output logic              mdr_out,
    output logic              c_sign_extended_out,
    output logic              inport_out,
    output logic              mar_enable,
    output logic              z_enable,
    output logic              pc_enable,
    output logic              mdr_enable,
    output logic              ir_enable,
    output logic              y_enable,
    output logic              pc_increment,
    output logic              alu_add,
    output logic              read,
    output logic              ram_write,
    output logic              gra,
    output logic              grb,
    output logic              r_in,
    output logic              r_out,
    output logic              ba_out,
    output logic              outport_enable,
    output logic              run,
    output logic              bad_op
);

    typedef enum logic [3:0] {
        S_INIT,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    state_t     state_q;
    state_t     after_last_d;
    logic [4:0] opcode;
    logic       is_ld, is_ldi, is_st, is_in, is_out, is_nop, is_halt, is_undef;
    logic       is_addr_calc;
    logic       unused_ir_bits;
    logic [6:0] bus_drv;

    assign opcode         = ir[DATA_W-1 -: 5];
    assign unused_ir_bits = ^ir[DATA_W-6:0];

    assign is_ld        = (opcode == OP_LD);
    assign is_ldi       = (opcode == OP_LDI);
    assign is_st        = (opcode == OP_ST);
    assign is_in        = (opcode == OP_IN);
    assign is_out       = (opcode == OP_OUT);
    assign is_nop       = (opcode == OP_NOP);
    assign is_halt      = (opcode == OP_HALT);
    assign is_undef     = !(is_ld || is_ldi || is_st || is_in || is_out || is_nop || is_halt);
    assign is_addr_calc = is_ld || is_ldi || is_st;

    // stop only matters on the edge that leaves an instruction's last state
    assign after_last_d = stop ? S_HALT : S_T0;

    assign pc_init = PC_RESET;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_INIT;
        end else begin
            case (state_q)
                S_INIT: state_q <= S_T0;
                S_T0:   state_q <= S_T1;
                S_T1:   state_q <= S_T2;
                S_T2:   state_q <= S_T3;
                S_T3: begin
                    if (is_halt)           state_q <= S_HALT;
                    else if (is_addr_calc) state_q <= S_T4;
                    else                   state_q <= after_last_d;
                end
                S_T4:   state_q <= S_T5;
                S_T5: begin
                    if (is_ld || is_st)    state_q <= S_T6;
                    else                   state_q <= after_last_d;
                end
                S_T6:   state_q <= S_T7;
                S_T7:   state_q <= after_last_d;
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_INIT;
            endcase
        end
    end

    always_comb begin
        pc_out              = 1'b0;
        zlo_out             = 1'b0;
        mdr_out             = 1'b0;
        c_sign_extended_out = 1'b0;
        inport_out          = 1'b0;
        mar_enable          = 1'b0;
        z_enable            = 1'b0;
        pc_enable           = 1'b0;
        mdr_enable          = 1'b0;
        ir_enable           = 1'b0;
        y_enable            = 1'b0;
        pc_increment        = 1'b0;
        alu_add             = 1'b0;
        read                = 1'b0;
        ram_write           = 1'b0;
        gra                 = 1'b0;
        grb                 = 1'b0;
        r_in                = 1'b0;
        r_out               = 1'b0;
        ba_out              = 1'b0;
        outport_enable      = 1'b0;
        bad_op              = 1'b0;
        // clr gates INIT/run directly so everything reads 0 while reset is held
        pc_init_enable      = clr && (state_q == S_INIT);
        run                 = clr && (state_q != S_HALT);
        case (state_q)
            S_T0: begin
                pc_out       = 1'b1;
                mar_enable   = 1'b1;
                pc_increment = 1'b1;
                z_enable     = 1'b1;
            end
            S_T1: begin
                zlo_out    = 1'b1;
                pc_enable  = 1'b1;
                read       = 1'b1;
                mdr_enable = 1'b1;
            end
            S_T2: begin
                mdr_out   = 1'b1;
                ir_enable = 1'b1;
            end
            S_T3: begin
                if (is_addr_calc) begin
                    grb      = 1'b1;
                    ba_out   = 1'b1;
                    y_enable = 1'b1;
                end else if (is_out) begin
                    gra            = 1'b1;
                    r_out          = 1'b1;
                    outport_enable = 1'b1;
                end else if (is_in) begin
                    inport_out = 1'b1;
                    gra        = 1'b1;
                    r_in       = 1'b1;
                end else if (is_undef) begin
                    bad_op = 1'b1;
                end
            end
            S_T4: begin
                c_sign_extended_out = 1'b1;
                alu_add             = 1'b1;
                z_enable            = 1'b1;
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_ld || is_st) begin
                    mar_enable = 1'b1;
                end else begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                end
            end
            S_T6: begin
                mdr_enable = 1'b1;
                if (is_st) begin
                    gra   = 1'b1;
                    r_out = 1'b1;
                end else begin
                    read = 1'b1;
                end
            end
            S_T7: begin
                if (is_st) begin
                    ram_write = 1'b1;
                end else begin
                    mdr_out = 1'b1;
                    gra     = 1'b1;
                    r_in    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus_drv = {pc_out, zlo_out, mdr_out, c_sign_extended_out, inport_out, r_out, ba_out};

    a_single_bus_driver: assert property (@(posedge clk) disable iff (!clr) $onehot0(bus_drv));
    a_read_write_excl:   assert property (@(posedge clk) disable iff (!clr) !(read && ram_write));

endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded random bench for control_unit: a step-table model of each instruction
// queues the expected strobes per cycle, and a negedge monitor compares them.
module tb_control_unit;

    localparam logic [31:0] PCR     = 32'h0000_001F;
    localparam logic [4:0]  OP_LD   = 5'b00000;
    localparam logic [4:0]  OP_LDI  = 5'b00001;
    localparam logic [4:0]  OP_ST   = 5'b00010;
    localparam logic [4:0]  OP_IN   = 5'b10110;
    localparam logic [4:0]  OP_OUT  = 5'b10111;
    localparam logic [4:0]  OP_NOP  = 5'b11010;
    localparam logic [4:0]  OP_HALT = 5'b11011;

    localparam logic [23:0] PIE   = 24'd1 << 0;
    localparam logic [23:0] PCOUT = 24'd1 << 1;
    localparam logic [23:0] ZLO   = 24'd1 << 2;
    localparam logic [23:0] MDRO  = 24'd1 << 3;
    localparam logic [23:0] CSE   = 24'd1 << 4;
    localparam logic [23:0] INP   = 24'd1 << 5;
    localparam logic [23:0] MAR   = 24'd1 << 6;
    localparam logic [23:0] ZEN   = 24'd1 << 7;
    localparam logic [23:0] PCEN  = 24'd1 << 8;
    localparam logic [23:0] MDREN = 24'd1 << 9;
    localparam logic [23:0] IREN  = 24'd1 << 10;
    localparam logic [23:0] YEN   = 24'd1 << 11;
    localparam logic [23:0] PCINC = 24'd1 << 12;
    localparam logic [23:0] ADD   = 24'd1 << 13;
    localparam logic [23:0] READ  = 24'd1 << 14;
    localparam logic [23:0] WRITE = 24'd1 << 15;
    localparam logic [23:0] GRA   = 24'd1 << 16;
    localparam logic [23:0] GRB   = 24'd1 << 17;
    localparam logic [23:0] RIN   = 24'd1 << 18;
    localparam logic [23:0] ROUT  = 24'd1 << 19;
    localparam logic [23:0] BA    = 24'd1 << 20;
    localparam logic [23:0] OUTEN = 24'd1 << 21;
    localparam logic [23:0] RUN   = 24'd1 << 22;
    localparam logic [23:0] BAD   = 24'd1 << 23;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [31:0] pc_init;
    logic pc_init_enable, pc_out, zlo_out, mdr_out, c_sign_extended_out, inport_out;
    logic mar_enable, z_enable, pc_enable, mdr_enable, ir_enable, y_enable;
    logic pc_increment, alu_add, read, ram_write, gra, grb, r_in, r_out, ba_out;
    logic outport_enable, run, bad_op;

    logic [55:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    control_unit #(.PC_RESET(PCR)) dut (
        .clk(clk), .clr(clr), .ir(ir), .stop(stop),
        .pc_init(pc_init), .pc_init_enable(pc_init_enable),
        .pc_out(pc_out), .zlo_out(zlo_out), .mdr_out(mdr_out),
        .c_sign_extended_out(c_sign_extended_out), .inport_out(inport_out),
        .mar_enable(mar_enable), .z_enable(z_enable), .pc_enable(pc_enable),
        .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable),
        .pc_increment(pc_increment), .alu_add(alu_add), .read(read),
        .ram_write(ram_write), .gra(gra), .grb(grb), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .outport_enable(outport_enable), .run(run), .bad_op(bad_op)
    );

    always #5 clk = ~clk;

    function automatic bit is_defined(input logic [4:0] op);
        return op == OP_LD || op == OP_LDI || op == OP_ST || op == OP_IN ||
               op == OP_OUT || op == OP_NOP || op == OP_HALT;
    endfunction

    function automatic logic [23:0] fetch_step(input int k);
        case (k)
            0:       return PCOUT | MAR | PCINC | ZEN;
            1:       return ZLO | PCEN | READ | MDREN;
            default: return MDRO | IREN;
        endcase
    endfunction

    function automatic int exec_len(input logic [4:0] op);
        if (op == OP_LDI)                return 3;
        if (op == OP_LD || op == OP_ST)  return 5;
        return 1;
    endfunction

    // Execute steps written straight from the instruction descriptions
    function automatic logic [23:0] exec_step(input logic [4:0] op, input int k);
        if (op == OP_LD || op == OP_LDI || op == OP_ST) begin
            if (k == 0) return GRB | BA | YEN;
            if (k == 1) return CSE | ADD | ZEN;
            if (k == 2) return (op == OP_LDI) ? (ZLO | GRA | RIN) : (ZLO | MAR);
            if (k == 3) return (op == OP_ST) ? (GRA | ROUT | MDREN) : (READ | MDREN);
            return (op == OP_ST) ? WRITE : (MDRO | GRA | RIN);
        end
        if (op == OP_OUT) return GRA | ROUT | OUTEN;
        if (op == OP_IN)  return INP | GRA | RIN;
        if (op == OP_NOP || op == OP_HALT) return 24'd0;
        return BAD;
    endfunction

    task automatic push_exp(input logic [23:0] s);
        exp_q.push_back({PCR, s});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        clr = 1'b0;
        push_exp(24'd0);
        tick();
        clr = 1'b1;
        push_exp(PIE | RUN);
        tick();
    endtask

    task automatic do_instr(input logic [31:0] w, input int stop_from, input bit rand_stop,
                            input bit stop_last, input int abort_at, output bit halted);
        int          n;
        bit          s;
        logic [4:0]  op;
        op     = w[31:27];
        n      = 3 + exec_len(op);
        halted = 1'b0;
        for (int k = 0; k < n; k++) begin
            ir = (k < 3) ? $urandom : w;
            if (k == n - 1)                        s = stop_last;
            else if (rand_stop)                    s = ($urandom_range(0, 1) == 1);
            else                                   s = 1'b0;
            if (stop_from >= 0 && k >= stop_from)  s = 1'b1;
            stop = s;
            if (k == abort_at) begin
                #1 clr = 1'b0;
                push_exp(24'd0);
                tick();
                push_exp(24'd0);
                tick();
                clr = 1'b1;
                push_exp(PIE | RUN);
                tick();
                return;
            end
            push_exp(RUN | ((k < 3) ? fetch_step(k) : exec_step(op, k - 3)));
            if (k == n - 1) halted = s || (op == OP_HALT);
            tick();
        end
    endtask

    task automatic do_halt(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            stop = ($urandom_range(0, 1) == 1);
            ir   = $urandom;
            push_exp(24'd0);
            tick();
        end
        stop = 1'b0;
        reset_pulse();
    endtask

    initial begin : monitor
        logic [55:0] exp_v;
        logic [55:0] act_v;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {pc_init, bad_op, run, outport_enable, ba_out, r_out, r_in, grb, gra,
                         ram_write, read, alu_add, pc_increment, y_enable, ir_enable,
                         mdr_enable, pc_enable, z_enable, mar_enable, inport_out,
                         c_sign_extended_out, mdr_out, zlo_out, pc_out, pc_init_enable};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL strobes cyc=%0d: got pc_init=%h strobes=%h, want pc_init=%h strobes=%h",
                             cyc, act_v[55:24], act_v[23:0], exp_v[55:24], exp_v[23:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit          h;
        int          sel;
        int          abort_at;
        logic [4:0]  op;
        logic [31:0] w;

        tick();
        push_exp(24'd0);
        tick();
        clr = 1'b1;
        push_exp(PIE | RUN);
        tick();

        do_instr(32'h0880_0005, -1, 1'b0, 1'b0, -1, h);
        do_instr(32'hB980_0000, -1, 1'b0, 1'b0, -1, h);
        do_instr({OP_ST, 27'h0123456}, -1, 1'b0, 1'b0, -1, h);
        do_instr(32'hF800_0000, -1, 1'b0, 1'b0, -1, h);
        do_instr({OP_IN, 27'h0}, -1, 1'b0, 1'b0, -1, h);
        do_instr({OP_LD, 27'h0000042}, 1, 1'b0, 1'b0, -1, h);
        if (h) do_halt(20);
        do_instr({OP_ST, 27'h0000077}, -1, 1'b0, 1'b0, 6, h);
        do_instr({OP_NOP, 27'h0}, -1, 1'b0, 1'b0, -1, h);
        do_instr({OP_HALT, 27'h0}, -1, 1'b0, 1'b0, -1, h);
        if (h) do_halt(3);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 8);
            case (sel)
                0: op = OP_LD;
                1: op = OP_LDI;
                2: op = OP_ST;
                3: op = OP_IN;
                4: op = OP_OUT;
                5: op = OP_NOP;
                6: op = OP_HALT;
                default: begin
                    op = 5'($urandom);
                    while (is_defined(op)) op = 5'($urandom);
                end
            endcase
            w        = {op, 27'($urandom)};
            abort_at = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 2 + exec_len(op)) : -1;
            do_instr(w, -1, 1'b1, ($urandom_range(0, 9) == 0), abort_at, h);
            if (h) do_halt($urandom_range(1, 5));
        end
        stop = 1'b0;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
